// File: rtl/traffic_light_monitor.sv
// Passive lamp-bus monitor: decodes phase, times it, checks sequencing, grants pedestrian walk.
// Latency: all outputs registered, one cycle after the lamp sample that caused them.
// Backpressure: none; pure observer, accepts a lamp sample every cycle. Optional counter: TLM_CYCLE_CNT_EN.
module traffic_light_monitor #(
    parameter int RED_MIN_CYC = 4,
    parameter int STUCK_CYC   = 250,
    parameter int WALK_DELAY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:2]  leds,
    input  logic        ped_req,
    input  logic        err_clr,
    output logic [1:0]  phase,
    output logic [7:0]  phase_time,
    output logic        walk,
    output logic        ped_pending,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [15:0] cycle_cnt
);

    typedef enum logic [2:0] {
        MON_DARK,
        MON_GREEN,
        MON_YELLOW,
        MON_RED,
        MON_FAULT
    } mon_state_t;

    localparam logic [7:0] RED_MIN_M1 = 8'(RED_MIN_CYC - 1);
    localparam logic [7:0] STUCK_M1   = 8'(STUCK_CYC - 1);
    localparam logic [7:0] WALK_D     = 8'(WALK_DELAY);

    mon_state_t state;
    mon_state_t lamp_state;
    mon_state_t state_nx;
    logic       lamp_multi;
    logic [7:0] pt_inc;
    logic [7:0] pt_nx;
    logic [2:0] new_code;
    logic [1:0] phase_nx;
    logic       walk_nx;
    logic       walk_rise;

    // Decode the lamp bus: green has precedence only matters when multi-hot, which is flagged separately
    always_comb begin
        lamp_multi = (leds[0] & leds[1]) | (leds[0] & leds[2]) | (leds[1] & leds[2]);
        if (leds[0])      lamp_state = MON_GREEN;
        else if (leds[1]) lamp_state = MON_YELLOW;
        else if (leds[2]) lamp_state = MON_RED;
        else              lamp_state = MON_DARK;
    end

    // Next state, phase timer and the single highest-priority error detected on this edge
    always_comb begin
        state_nx = state;
        pt_inc   = (phase_time == 8'hFF) ? 8'hFF : phase_time + 8'd1;
        pt_nx    = pt_inc;
        new_code = 3'd0;
        if (state == MON_FAULT) begin
            // Only an explicit clear with a clean pattern lets us trust the lamps again
            pt_nx = 8'd0;
            if (err_clr && !lamp_multi) state_nx = lamp_state;
        end else if (lamp_multi) begin
            state_nx = MON_FAULT;
            pt_nx    = 8'd0;
            new_code = 3'd1;
        end else if (lamp_state != state) begin
            // Follow the lamps even on a bad transition so timing stays meaningful
            state_nx = lamp_state;
            pt_nx    = 8'd0;
            if ((state == MON_YELLOW && lamp_state == MON_GREEN) ||
                (state == MON_RED    && lamp_state == MON_YELLOW) ||
                (state == MON_DARK   && lamp_state == MON_RED))
                new_code = 3'd2;
            else if (state == MON_RED && lamp_state == MON_GREEN && phase_time < RED_MIN_M1)
                new_code = 3'd3;
        end else if (state != MON_DARK && pt_inc == STUCK_M1 && phase_time != STUCK_M1) begin
            // Fires only on the edge the timer first reaches the limit, so once per phase
            new_code = 3'd4;
        end
    end

    // Output phase encoding plus walk grant, which lives only inside one red phase
    always_comb begin
        case (state_nx)
            MON_GREEN:  phase_nx = 2'd1;
            MON_YELLOW: phase_nx = 2'd2;
            MON_RED:    phase_nx = 2'd3;
            default:    phase_nx = 2'd0;
        endcase
        walk_nx   = (state_nx == MON_RED) && (walk || (ped_pending && pt_nx >= WALK_D));
        walk_rise = walk_nx && !walk;
    end

    // Monitor FSM with registered outputs; sticky error holds the first code until cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= MON_DARK;
            phase       <= 2'd0;
            phase_time  <= 8'd0;
            walk        <= 1'b0;
            ped_pending <= 1'b0;
            err         <= 1'b0;
            err_code    <= 3'd0;
        end else begin
            state       <= state_nx;
            phase       <= phase_nx;
            phase_time  <= pt_nx;
            walk        <= walk_nx;
            // A request on the granting edge is kept for the next red phase
            ped_pending <= ped_req | (ped_pending & ~walk_rise);
            if (err_clr) begin
                err      <= 1'b0;
                err_code <= 3'd0;
            end else if (!err && new_code != 3'd0) begin
                err      <= 1'b1;
                err_code <= new_code;
            end
        end
    end

`ifdef TLM_CYCLE_CNT_EN
    logic        red_from_yellow;
    logic [15:0] cnt_q;
    logic        cnt_hit;

    // A full cycle is yellow->red->green with both transitions clean
    always_comb begin
        cnt_hit = (state == MON_RED) && !lamp_multi && (lamp_state == MON_GREEN) &&
                  (phase_time >= RED_MIN_M1) && red_from_yellow;
    end

    // Remember how red was entered and count completed cycles; err_clr never touches this
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            red_from_yellow <= 1'b0;
            cnt_q           <= 16'd0;
        end else begin
            if (state_nx == MON_RED && state != MON_RED)
                red_from_yellow <= (state == MON_YELLOW);
            if (cnt_hit && cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
        end
    end

    assign cycle_cnt = cnt_q;
`else
    assign cycle_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: reset, walk sequence, short red, faults, stuck, idle red.
// Inputs driven 1 time unit after the rising edge; outputs sampled at that same point.
// Expected values are hand-derived constants from the lamp sequences applied.
module tb_traffic_light_monitor;

    logic        clk;
    logic        rst;
    logic [0:2]  leds;
    logic        ped_req;
    logic        err_clr;
    logic [1:0]  phase;
    logic [7:0]  phase_time;
    logic        walk;
    logic        ped_pending;
    logic        err;
    logic [2:0]  err_code;
    logic [15:0] cycle_cnt;

    int checks;
    int errors;

`ifdef TLM_CYCLE_CNT_EN
    localparam logic [15:0] CNT_ONE = 16'd1;
    localparam logic [15:0] CNT_TWO = 16'd2;
`else
    localparam logic [15:0] CNT_ONE = 16'd0;
    localparam logic [15:0] CNT_TWO = 16'd0;
`endif

    traffic_light_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .leds        (leds),
        .ped_req     (ped_req),
        .err_clr     (err_clr),
        .phase       (phase),
        .phase_time  (phase_time),
        .walk        (walk),
        .ped_pending (ped_pending),
        .err         (err),
        .err_code    (err_code),
        .cycle_cnt   (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply a lamp pattern for n edges, leaving time 1 unit after the last edge
    task automatic cyc(input logic [0:2] l, input int n);
        leds = l;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; leds = 3'b000; ped_req = 1'b0; err_clr = 1'b0;
        #12;
        checks++;
        if ({phase, phase_time, walk, ped_pending, err, err_code, cycle_cnt} !== 32'd0) begin
            errors++;
            $display("FAIL reset_state got %h want 0",
                     {phase, phase_time, walk, ped_pending, err, err_code, cycle_cnt});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        cyc(3'b100, 5);
        checks++;
        if (phase !== 2'd1 || phase_time !== 8'd4 || err !== 1'b0) begin
            errors++;
            $display("FAIL green5 got phase=%0d pt=%0d err=%0b want 1 4 0", phase, phase_time, err);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (phase !== 2'd0 || phase_time !== 8'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got phase=%0d pt=%0d want 0 0", phase, phase_time);
        end
        leds = 3'b000;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_sequence();
        int walk_bad;
        walk_bad = 0;
        cyc(3'b100, 3);
        ped_req = 1'b1;
        cyc(3'b100, 1);
        ped_req = 1'b0;
        cyc(3'b100, 6);
        checks++;
        if (ped_pending !== 1'b1 || walk !== 1'b0) begin
            errors++;
            $display("FAIL seq_pending got pend=%0b walk=%0b want 1 0", ped_pending, walk);
        end
        cyc(3'b010, 3);
        cyc(3'b001, 1);
        checks++;
        if (phase !== 2'd3 || phase_time !== 8'd0 || walk !== 1'b0) begin
            errors++;
            $display("FAIL seq_red1 got phase=%0d pt=%0d walk=%0b want 3 0 0", phase, phase_time, walk);
        end
        cyc(3'b001, 1);
        checks++;
        if (walk !== 1'b1 || ped_pending !== 1'b0) begin
            errors++;
            $display("FAIL seq_walk_on got walk=%0b pend=%0b want 1 0", walk, ped_pending);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(3'b001, 1);
            if (walk !== 1'b1) walk_bad++;
        end
        checks++;
        if (walk_bad != 0) begin
            errors++;
            $display("FAIL seq_walk_hold got %0d low cycles want 0", walk_bad);
        end
        cyc(3'b100, 1);
        checks++;
        if (walk !== 1'b0 || err !== 1'b0 || phase !== 2'd1 || cycle_cnt !== CNT_ONE) begin
            errors++;
            $display("FAIL seq_green got walk=%0b err=%0b phase=%0d cnt=%0d want 0 0 1 %0d",
                     walk, err, phase, cycle_cnt, CNT_ONE);
        end
    endtask

    task automatic test_short_red();
        cyc(3'b010, 3);
        cyc(3'b001, 2);
        cyc(3'b100, 1);
        checks++;
        if (err !== 1'b1 || err_code !== 3'd3 || phase !== 2'd1 || cycle_cnt !== CNT_ONE) begin
            errors++;
            $display("FAIL short_red got err=%0b code=%0d phase=%0d cnt=%0d want 1 3 1 %0d",
                     err, err_code, phase, cycle_cnt, CNT_ONE);
        end
        cyc(3'b010, 1);
        cyc(3'b100, 1);
        checks++;
        if (err_code !== 3'd3) begin
            errors++;
            $display("FAIL sticky_code got %0d want 3", err_code);
        end
        err_clr = 1'b1;
        cyc(3'b100, 1);
        err_clr = 1'b0;
        checks++;
        if (err !== 1'b0 || err_code !== 3'd0) begin
            errors++;
            $display("FAIL clear_short got err=%0b code=%0d want 0 0", err, err_code);
        end
    endtask

    task automatic test_illegal_multihot();
        cyc(3'b010, 1);
        cyc(3'b100, 1);
        checks++;
        if (err !== 1'b1 || err_code !== 3'd2 || phase !== 2'd1) begin
            errors++;
            $display("FAIL illegal got err=%0b code=%0d phase=%0d want 1 2 1", err, err_code, phase);
        end
        err_clr = 1'b1;
        cyc(3'b100, 1);
        err_clr = 1'b0;
        cyc(3'b110, 1);
        checks++;
        if (err !== 1'b1 || err_code !== 3'd1 || phase !== 2'd0 || phase_time !== 8'd0) begin
            errors++;
            $display("FAIL multihot got err=%0b code=%0d phase=%0d pt=%0d want 1 1 0 0",
                     err, err_code, phase, phase_time);
        end
        err_clr = 1'b1;
        cyc(3'b110, 1);
        checks++;
        if (err !== 1'b0 || phase !== 2'd0 || phase_time !== 8'd0 || walk !== 1'b0) begin
            errors++;
            $display("FAIL fault_hold got err=%0b phase=%0d pt=%0d want 0 0 0", err, phase, phase_time);
        end
        cyc(3'b001, 1);
        err_clr = 1'b0;
        checks++;
        if (phase !== 2'd3 || phase_time !== 8'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL resync got phase=%0d pt=%0d err=%0b want 3 0 0", phase, phase_time, err);
        end
        cyc(3'b001, 1);
        checks++;
        if (phase !== 2'd3 || phase_time !== 8'd1 || err !== 1'b0) begin
            errors++;
            $display("FAIL resync_run got phase=%0d pt=%0d err=%0b want 3 1 0", phase, phase_time, err);
        end
        cyc(3'b000, 1);
    endtask

    task automatic test_stuck();
        cyc(3'b100, 249);
        checks++;
        if (err !== 1'b0 || phase_time !== 8'd248) begin
            errors++;
            $display("FAIL stuck_early got err=%0b pt=%0d want 0 248", err, phase_time);
        end
        cyc(3'b100, 1);
        checks++;
        if (err !== 1'b1 || err_code !== 3'd4 || phase_time !== 8'd249) begin
            errors++;
            $display("FAIL stuck got err=%0b code=%0d pt=%0d want 1 4 249", err, err_code, phase_time);
        end
        cyc(3'b100, 10);
        checks++;
        if (phase_time !== 8'd255 || err_code !== 3'd4) begin
            errors++;
            $display("FAIL saturate got pt=%0d code=%0d want 255 4", phase_time, err_code);
        end
        err_clr = 1'b1;
        cyc(3'b010, 1);
        err_clr = 1'b0;
        checks++;
        if (err !== 1'b0 || phase !== 2'd2) begin
            errors++;
            $display("FAIL stuck_clear got err=%0b phase=%0d want 0 2", err, phase);
        end
    endtask

    task automatic test_no_request();
        int walk_seen;
        walk_seen = 0;
        checks++;
        if (ped_pending !== 1'b0) begin
            errors++;
            $display("FAIL idle_pending got %0b want 0", ped_pending);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(3'b001, 1);
            if (walk !== 1'b0) walk_seen++;
        end
        checks++;
        if (walk_seen != 0) begin
            errors++;
            $display("FAIL idle_walk got %0d walk cycles want 0", walk_seen);
        end
        cyc(3'b100, 1);
        checks++;
        if (err !== 1'b0 || phase !== 2'd1 || cycle_cnt !== CNT_TWO) begin
            errors++;
            $display("FAIL idle_green got err=%0b phase=%0d cnt=%0d want 0 1 %0d",
                     err, phase, cycle_cnt, CNT_TWO);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sequence();
        test_short_red();
        test_illegal_multihot();
        test_stuck();
        test_no_request();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
